// File: rtl/fetch_unit_pkg.sv
// Shared state codes and opcode fields for the control state machine
// and the fetch datapath.
package fetch_unit_pkg;

  typedef enum logic [5:0] {
    S_IDLE   = 6'd0,
    S_FETCH1 = 6'd1,
    S_FETCH2 = 6'd2,
    S_FETCH3 = 6'd3,
    S_LDR11  = 6'd4,
    S_LDR12  = 6'd5,
    S_LDR13  = 6'd6,
    S_LDR14  = 6'd7,
    S_LDR21  = 6'd8,
    S_LDR22  = 6'd9,
    S_LDR23  = 6'd10,
    S_LDR24  = 6'd11,
    S_STAC1  = 6'd12,
    S_STAC2  = 6'd13,
    S_STAC3  = 6'd14,
    S_STAC4  = 6'd15,
    S_ADD    = 6'd16,
    S_MUL    = 6'd17
  } state_t;

  localparam logic [5:0] OP_HALT = 6'd0;
  localparam logic [5:0] OP_LDR1 = 6'd1;
  localparam logic [5:0] OP_LDR2 = 6'd2;
  localparam logic [5:0] OP_STAC = 6'd3;
  localparam logic [5:0] OP_ADD  = 6'd4;
  localparam logic [5:0] OP_MUL  = 6'd5;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 10;

endpackage

// File: rtl/fetch_unit_reg.sv
// Width-N register with synchronous reset, load and increment enables.
// Load takes priority over increment.
module fetch_reg #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ld,
  input  logic         inc,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset)
      q <= '0;
    else if (ld)
      q <= d;
    else if (inc)
      q <= q + 1'b1;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch datapath: PC, AR, IR and DR driven by the control state code,
// plus sticky halt/illegal flags and a saturating fetch counter.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [5:0]        state,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic [DATA_W-1:0] IR,
  output logic [DATA_W-1:0] DR,
  output logic [ADDR_W-1:0] PC,
  output logic              halted,
  output logic              illegal_op,
  output logic [15:0]       fetch_cnt
);

  state_t      st;
  logic        ar_ld;
  logic        ir_ld;
  logic        dr_ld;
  logic        pc_inc;
  logic [5:0]  opc;
  logic [ADDR_W-1:0] ar;

  assign st  = state_t'(state);
  assign opc = mem_rdata[OPC_MSB:OPC_LSB];
  assign mem_addr = ar;

  always_comb begin
    ar_ld     = 1'b0;
    ir_ld     = 1'b0;
    dr_ld     = 1'b0;
    pc_inc    = 1'b0;
    mem_rd_en = 1'b0;
    unique case (1'b1)
      (st == S_FETCH1 || st == S_LDR11 || st == S_LDR21):
        ar_ld = 1'b1;
      (st == S_FETCH2 || st == S_LDR12 || st == S_LDR22):
        mem_rd_en = 1'b1;
      (st == S_FETCH3): begin
        ir_ld  = 1'b1;
        pc_inc = 1'b1;
      end
      (st == S_LDR13 || st == S_LDR23): begin
        dr_ld  = 1'b1;
        pc_inc = 1'b1;
      end
      default: ;
    endcase
  end

  fetch_reg #(.W(ADDR_W)) u_pc (
    .clock (clock),
    .reset (reset),
    .ld    (1'b0),
    .inc   (pc_inc),
    .d     ('0),
    .q     (PC)
  );

  fetch_reg #(.W(ADDR_W)) u_ar (
    .clock (clock),
    .reset (reset),
    .ld    (ar_ld),
    .inc   (1'b0),
    .d     (PC),
    .q     (ar)
  );

  fetch_reg #(.W(DATA_W)) u_ir (
    .clock (clock),
    .reset (reset),
    .ld    (ir_ld),
    .inc   (1'b0),
    .d     (mem_rdata),
    .q     (IR)
  );

  fetch_reg #(.W(DATA_W)) u_dr (
    .clock (clock),
    .reset (reset),
    .ld    (dr_ld),
    .inc   (1'b0),
    .d     (mem_rdata),
    .q     (DR)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      halted     <= 1'b0;
      illegal_op <= 1'b0;
      fetch_cnt  <= '0;
    end else if (ir_ld) begin
      if (opc == OP_HALT)
        halted <= 1'b1;
      if (opc > OP_MUL)
        illegal_op <= 1'b1;
      if (fetch_cnt != 16'hFFFF)
        fetch_cnt <= fetch_cnt + 16'd1;
    end
  end

endmodule
